// File: rtl/bp_pkg.sv
// Shared definitions for the gshare branch predictor.
// Holds the branch-type encodings carried from EX, the 2-bit saturating
// counter states and the counter update helper.
package bp_pkg;

    // Branch types as reported by EX and stored in the BTB
    localparam logic [1:0] BR_COND = 2'b00;
    localparam logic [1:0] BR_JUMP = 2'b01;
    localparam logic [1:0] BR_CALL = 2'b10;
    localparam logic [1:0] BR_RET  = 2'b11;

    // 2-bit counter states; the MSB is the taken prediction
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic up);
        logic [1:0] res;
        res = cnt;
        if (up && cnt != ST)
            res = cnt + 2'd1;
        else if (!up && cnt != SNT)
            res = cnt - 2'd1;
        return res;
    endfunction

endpackage

// File: rtl/bp_ras.sv
// Circular return-address stack.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_data   speculative call: write slot ptr+1 and advance
//   pop               speculative return: step pointer back
//   restore*          EX recovery: reload pointer from a checkpoint, then
//                     optionally apply the recovering call/return on top
//   ptr, top          current pointer and the entry it addresses
// The stack never reports overflow/underflow; the pointer simply wraps and
// the oldest entry is overwritten.
module bp_ras #(
    parameter int WIDTH       = 32,
    parameter int RAS_ENTRIES = 8,
    localparam int PW         = $clog2(RAS_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    input  logic             restore,
    input  logic [PW-1:0]    restore_ptr,
    input  logic             restore_push,
    input  logic             restore_pop,
    input  logic [WIDTH-1:0] restore_data,
    output logic [PW-1:0]    ptr,
    output logic [WIDTH-1:0] top
);

    logic [WIDTH-1:0] stack [RAS_ENTRIES];
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    ptr_nxt;
    logic [PW-1:0]    wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic             wr_en;

    // Restore wins over any speculative push/pop in the same cycle
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = ptr_q + 1'b1;
        wr_data = push_data;
        ptr_nxt = ptr_q;
        if (restore) begin
            ptr_nxt = restore_ptr;
            wr_idx  = restore_ptr + 1'b1;
            wr_data = restore_data;
            if (restore_push) begin
                wr_en   = 1'b1;
                ptr_nxt = restore_ptr + 1'b1;
            end else if (restore_pop) begin
                ptr_nxt = restore_ptr - 1'b1;
            end
        end else if (push) begin
            wr_en   = 1'b1;
            ptr_nxt = ptr_q + 1'b1;
        end else if (pop) begin
            ptr_nxt = ptr_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            for (int i = 0; i < RAS_ENTRIES; i++)
                stack[i] <= '0;
        end else begin
            ptr_q <= ptr_nxt;
            if (wr_en)
                stack[wr_idx] <= wr_data;
        end
    end

    assign ptr = ptr_q;
    assign top = stack[ptr_q];

endmodule

// File: rtl/gshare_branch_predictor.sv
// IF-stage gshare branch predictor with tagged BTB and checkpointed RAS.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   pc_in, ctrl_stall        IF fetch PC; stall freezes speculative state
//   branch_predict_pc_out    predicted next PC (combinational)
//   branch_taken_out         predicted redirect (combinational)
//   pred_ghr_out             GHR before this fetch, carried to EX
//   pred_ras_ptr_out         RAS pointer before this fetch, carried to EX
//   branch_ex_*              resolved control transfer from EX
//   branch_miss              EX mispredict, qualified by branch_ex_req
// Optional (macro BP_PERF_CNT_EN):
//   perf_branch_cnt, perf_miss_cnt  saturating 32-bit event counters
// Lookup is combinational; every table write lands at the clock edge, so a
// same-cycle EX write to the entry being looked up is seen one cycle later.
module gshare_branch_predictor
    import bp_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int PHT_ENTRIES = 256,
    parameter int HIST_LEN    = 8,
    parameter int BTB_ENTRIES = 64,
    parameter int RAS_ENTRIES = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [WIDTH-1:0]               pc_in,
    input  logic                           ctrl_stall,
    output logic [WIDTH-1:0]               branch_predict_pc_out,
    output logic                           branch_taken_out,
    output logic [HIST_LEN-1:0]            pred_ghr_out,
    output logic [$clog2(RAS_ENTRIES)-1:0] pred_ras_ptr_out,
    input  logic                           branch_ex_req,
    input  logic [WIDTH-1:0]               branch_ex_pc,
    input  logic                           branch_ex_taken,
    input  logic [1:0]                     branch_ex_type,
    input  logic [WIDTH-1:0]               branch_ex_next_pc,
    input  logic [HIST_LEN-1:0]            branch_ex_ghr,
    input  logic [$clog2(RAS_ENTRIES)-1:0] branch_ex_ras_ptr,
    input  logic                           branch_miss
`ifdef BP_PERF_CNT_EN
    ,
    output logic [31:0]                    perf_branch_cnt,
    output logic [31:0]                    perf_miss_cnt
`endif
);

    localparam int PHT_IW = $clog2(PHT_ENTRIES);
    localparam int BTB_IW = $clog2(BTB_ENTRIES);
    localparam int TAG_W  = WIDTH - BTB_IW - 2;
    localparam int RAS_PW = $clog2(RAS_ENTRIES);

    logic [1:0]             pht        [PHT_ENTRIES];
    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
    logic [1:0]             btb_type   [BTB_ENTRIES];
    logic [WIDTH-1:0]       btb_target [BTB_ENTRIES];
    logic [HIST_LEN-1:0]    ghr;

    logic [PHT_IW-1:0] if_pht_idx, ex_pht_idx;
    logic [BTB_IW-1:0] if_btb_idx, ex_btb_idx;
    logic              if_hit;
    logic [1:0]        if_type;
    logic [WIDTH-1:0]  seq_pc;
    logic [WIDTH-1:0]  ras_top;
    logic [RAS_PW-1:0] ras_ptr;
    logic              recover;
    logic              spec_en;

    // Address bits below the word boundary never select an entry
    logic unused_lsb;
    assign unused_lsb = ^{pc_in[1:0], branch_ex_pc[1:0]};

    // ---------------- IF lookup ----------------
    assign if_pht_idx = pc_in[PHT_IW+1:2] ^ PHT_IW'(ghr);
    assign if_btb_idx = pc_in[BTB_IW+1:2];
    assign if_hit     = btb_valid[if_btb_idx] &&
                        (btb_tag[if_btb_idx] == pc_in[WIDTH-1:BTB_IW+2]);
    assign if_type    = btb_type[if_btb_idx];
    assign seq_pc     = pc_in + WIDTH'(4);

    always_comb begin
        branch_taken_out      = 1'b0;
        branch_predict_pc_out = seq_pc;
        if (if_hit) begin
            case (if_type)
                BR_RET: begin
                    branch_taken_out      = 1'b1;
                    branch_predict_pc_out = ras_top;
                end
                BR_COND: begin
                    if (pht[if_pht_idx][1]) begin
                        branch_taken_out      = 1'b1;
                        branch_predict_pc_out = btb_target[if_btb_idx];
                    end
                end
                default: begin
                    branch_taken_out      = 1'b1;
                    branch_predict_pc_out = btb_target[if_btb_idx];
                end
            endcase
        end
    end

    assign pred_ghr_out     = ghr;
    assign pred_ras_ptr_out = ras_ptr;

    // A recovering EX instruction discards whatever IF would have done
    assign recover = branch_ex_req && branch_miss;
    assign spec_en = if_hit && !ctrl_stall && !recover;

    // ---------------- Global history ----------------
    // The sized cast keeps the low HIST_LEN bits of {history, outcome},
    // which is a left shift with the new outcome in bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ghr <= '0;
        else if (recover)
            ghr <= (branch_ex_type == BR_COND) ?
                   HIST_LEN'({branch_ex_ghr, branch_ex_taken}) : branch_ex_ghr;
        else if (spec_en && if_type == BR_COND)
            ghr <= HIST_LEN'({ghr, branch_taken_out});
    end

    // ---------------- PHT training ----------------
    assign ex_pht_idx = branch_ex_pc[PHT_IW+1:2] ^ PHT_IW'(branch_ex_ghr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PHT_ENTRIES; i++)
                pht[i] <= WNT;
        end else if (branch_ex_req && branch_ex_type == BR_COND) begin
            pht[ex_pht_idx] <= sat_update(pht[ex_pht_idx], branch_ex_taken);
        end
    end

    // ---------------- BTB install ----------------
    assign ex_btb_idx = branch_ex_pc[BTB_IW+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btb_valid <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_tag[i]    <= '0;
                btb_type[i]   <= BR_COND;
                btb_target[i] <= '0;
            end
        end else if (branch_ex_req && branch_ex_taken) begin
            btb_valid[ex_btb_idx]  <= 1'b1;
            btb_tag[ex_btb_idx]    <= branch_ex_pc[WIDTH-1:BTB_IW+2];
            btb_type[ex_btb_idx]   <= branch_ex_type;
            btb_target[ex_btb_idx] <= branch_ex_next_pc;
        end
    end

    // ---------------- Return stack ----------------
    bp_ras #(
        .WIDTH       (WIDTH),
        .RAS_ENTRIES (RAS_ENTRIES)
    ) u_ras (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (spec_en && if_type == BR_CALL),
        .pop          (spec_en && if_type == BR_RET),
        .push_data    (seq_pc),
        .restore      (recover),
        .restore_ptr  (branch_ex_ras_ptr),
        .restore_push (branch_ex_type == BR_CALL),
        .restore_pop  (branch_ex_type == BR_RET),
        .restore_data (branch_ex_pc + WIDTH'(4)),
        .ptr          (ras_ptr),
        .top          (ras_top)
    );

`ifdef BP_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branch_cnt <= '0;
            perf_miss_cnt   <= '0;
        end else begin
            if (branch_ex_req && perf_branch_cnt != '1)
                perf_branch_cnt <= perf_branch_cnt + 32'd1;
            if (recover && perf_miss_cnt != '1)
                perf_miss_cnt <= perf_miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gshare_branch_predictor.sv
module tb_gshare_branch_predictor;
    import bp_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_in;
    logic        ctrl_stall;
    logic [31:0] branch_predict_pc_out;
    logic        branch_taken_out;
    logic [7:0]  pred_ghr_out;
    logic [2:0]  pred_ras_ptr_out;
    logic        branch_ex_req;
    logic [31:0] branch_ex_pc;
    logic        branch_ex_taken;
    logic [1:0]  branch_ex_type;
    logic [31:0] branch_ex_next_pc;
    logic [7:0]  branch_ex_ghr;
    logic [2:0]  branch_ex_ras_ptr;
    logic        branch_miss;
`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_branch_cnt;
    logic [31:0] perf_miss_cnt;
`endif

    gshare_branch_predictor dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .pc_in                 (pc_in),
        .ctrl_stall            (ctrl_stall),
        .branch_predict_pc_out (branch_predict_pc_out),
        .branch_taken_out      (branch_taken_out),
        .pred_ghr_out          (pred_ghr_out),
        .pred_ras_ptr_out      (pred_ras_ptr_out),
        .branch_ex_req         (branch_ex_req),
        .branch_ex_pc          (branch_ex_pc),
        .branch_ex_taken       (branch_ex_taken),
        .branch_ex_type        (branch_ex_type),
        .branch_ex_next_pc     (branch_ex_next_pc),
        .branch_ex_ghr         (branch_ex_ghr),
        .branch_ex_ras_ptr     (branch_ex_ras_ptr),
        .branch_miss           (branch_miss)
`ifdef BP_PERF_CNT_EN
        ,
        .perf_branch_cnt       (perf_branch_cnt),
        .perf_miss_cnt         (perf_miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: plain integer tables indexed by word address
    int          m_pht [256];
    bit          m_bv  [64];
    logic [31:0] m_tag [64];
    int          m_type[64];
    logic [31:0] m_tgt [64];
    logic [31:0] m_ras [8];
    int          m_ghr;
    int          m_ptr;

    bit          p_hit;
    bit          p_taken;
    int          p_type;
    logic [31:0] p_pred;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 256; i++) m_pht[i] = 1;
        for (int i = 0; i < 64; i++) begin
            m_bv[i] = 0; m_tag[i] = 0; m_type[i] = 0; m_tgt[i] = 0;
        end
        for (int i = 0; i < 8; i++) m_ras[i] = 0;
        m_ghr = 0;
        m_ptr = 0;
    endtask

    task automatic m_predict();
        int idx, b;
        idx = int'((pc_in / 4) % 256) ^ m_ghr;
        b   = int'((pc_in / 4) % 64);
        p_hit   = m_bv[b] && (m_tag[b] == pc_in / 256);
        p_type  = m_type[b];
        p_taken = 0;
        p_pred  = pc_in + 32'd4;
        if (p_hit) begin
            if (p_type == 3) begin
                p_taken = 1; p_pred = m_ras[m_ptr];
            end else if (p_type != 0 || m_pht[idx] >= 2) begin
                p_taken = 1; p_pred = m_tgt[b];
            end
        end
    endtask

    task automatic m_update();
        int e, b, t;
        t = int'(branch_ex_type);
        if (branch_ex_req) begin
            if (t == 0) begin
                e = int'((branch_ex_pc / 4) % 256) ^ int'(branch_ex_ghr);
                if (branch_ex_taken) m_pht[e] = (m_pht[e] == 3) ? 3 : m_pht[e] + 1;
                else                 m_pht[e] = (m_pht[e] == 0) ? 0 : m_pht[e] - 1;
            end
            if (branch_ex_taken) begin
                b = int'((branch_ex_pc / 4) % 64);
                m_bv[b] = 1; m_tag[b] = branch_ex_pc / 256;
                m_type[b] = t; m_tgt[b] = branch_ex_next_pc;
            end
        end
        if (branch_ex_req && branch_miss) begin
            m_ghr = (t == 0) ? (int'(branch_ex_ghr) * 2 + int'(branch_ex_taken)) % 256
                             : int'(branch_ex_ghr);
            if (t == 2) begin
                m_ptr = (int'(branch_ex_ras_ptr) + 1) % 8;
                m_ras[m_ptr] = branch_ex_pc + 32'd4;
            end else if (t == 3) begin
                m_ptr = (int'(branch_ex_ras_ptr) + 7) % 8;
            end else begin
                m_ptr = int'(branch_ex_ras_ptr);
            end
        end else if (!ctrl_stall && p_hit) begin
            if (p_type == 0) m_ghr = (m_ghr * 2 + int'(p_taken)) % 256;
            else if (p_type == 2) begin
                m_ptr = (m_ptr + 1) % 8;
                m_ras[m_ptr] = pc_in + 32'd4;
            end else if (p_type == 3) m_ptr = (m_ptr + 7) % 8;
        end
    endtask

    // One clock: compare all outputs with the model, then advance the model
    task automatic tick(input string tag);
        @(negedge clk);
        m_predict();
        chk({tag, ".taken"}, 32'(branch_taken_out), 32'(p_taken));
        chk({tag, ".pred"},  branch_predict_pc_out, p_pred);
        chk({tag, ".ghr"},   32'(pred_ghr_out), m_ghr);
        chk({tag, ".ptr"},   32'(pred_ras_ptr_out), m_ptr);
        m_update();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input logic [31:0] pc, input logic tk, input logic [1:0] ty,
                      input logic [31:0] nxt, input logic [7:0] g, input logic [2:0] p,
                      input logic miss);
        branch_ex_req = 1'b1; branch_ex_pc = pc; branch_ex_taken = tk;
        branch_ex_type = ty; branch_ex_next_pc = nxt; branch_ex_ghr = g;
        branch_ex_ras_ptr = p; branch_miss = miss;
    endtask

    task automatic clr_ex();
        branch_ex_req = 1'b0; branch_ex_pc = '0; branch_ex_taken = 1'b0;
        branch_ex_type = BR_COND; branch_ex_next_pc = '0; branch_ex_ghr = '0;
        branch_ex_ras_ptr = '0; branch_miss = 1'b0;
    endtask

    logic [31:0] pool [12];

    function automatic logic [31:0] pick();
        logic [31:0] r;
        if ($urandom_range(4) == 0) r = $urandom & 32'hFFFF_FFFC;
        else r = pool[$urandom_range(11)];
        return r;
    endfunction

    initial begin
        int g0, p0;
        rst_n = 1'b0; pc_in = 32'h100; ctrl_stall = 1'b0;
        clr_ex();
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.taken", 32'(branch_taken_out), 32'd0);
        chk("rst.pred",  branch_predict_pc_out, 32'h104);
        chk("rst.ghr",   32'(pred_ghr_out), 32'd0);
        chk("rst.ptr",   32'(pred_ras_ptr_out), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        tick("fetch100");

        // Cond at 0x200 trained taken three times with GHR 0
        ex(32'h200, 1'b1, BR_COND, 32'h240, 8'h00, 3'd0, 1'b0);
        repeat (3) tick("train200");
        clr_ex();
        pc_in = 32'h200; #1;
        chk("cond200.taken", 32'(branch_taken_out), 32'd1);
        chk("cond200.pred",  branch_predict_pc_out, 32'h240);
        tick("fetch200");

        // Call 0x300 -> 0x800, ret at 0x820
        pc_in = 32'h100;
        ex(32'h300, 1'b1, BR_CALL, 32'h800, 8'h00, 3'd0, 1'b0);
        tick("inst_call");
        ex(32'h820, 1'b1, BR_RET, 32'h304, 8'h00, 3'd0, 1'b0);
        tick("inst_ret");
        clr_ex();
        p0 = m_ptr;
        pc_in = 32'h300;
        tick("fetch_call");
        chk("call.ptr", 32'(pred_ras_ptr_out), (p0 + 1) % 8);
        pc_in = 32'h820; #1;
        chk("ret.pred", branch_predict_pc_out, 32'h304);
        tick("fetch_ret");
        chk("ret.ptr", 32'(pred_ras_ptr_out), p0);

        // Same PC 0x400, opposite training under GHR 0 and GHR 1
        pc_in = 32'h100;
        ex(32'h400, 1'b1, BR_COND, 32'h480, 8'h00, 3'd0, 1'b0);
        repeat (2) tick("train400_g0");
        ex(32'h400, 1'b0, BR_COND, 32'h404, 8'h01, 3'd0, 1'b0);
        tick("train400_g1");
        ex(32'h100, 1'b0, BR_JUMP, 32'h104, 8'h00, 3'(m_ptr), 1'b1);
        tick("ghr_clear");
        clr_ex();
        pc_in = 32'h400; #1;
        chk("g0.taken", 32'(branch_taken_out), 32'd1);
        chk("g0.pred",  branch_predict_pc_out, 32'h480);
        tick("fetch400_g0");
        chk("g1.taken", 32'(branch_taken_out), 32'd0);
        chk("g1.pred",  branch_predict_pc_out, 32'h404);
        tick("fetch400_g1");

        // Recovery beats a same-cycle IF cond hit
        ex(32'h400, 1'b0, BR_COND, 32'h404, 8'h5A, 3'd5, 1'b1);
        tick("recover");
        clr_ex();
        chk("recover.ghr", 32'(pred_ghr_out), 32'hB4);
        chk("recover.ptr", 32'(pred_ras_ptr_out), 32'd5);

        // Nine nested calls into an eight-deep stack
        pc_in = 32'h100;
        for (int k = 0; k < 9; k++) begin
            ex(32'h2040 + 32'(4 * k), 1'b1, BR_CALL, 32'h5000 + 32'(16 * k), 8'h00, 3'd0, 1'b0);
            tick("inst_calls");
        end
        ex(32'h30A0, 1'b1, BR_RET, 32'h0, 8'h00, 3'd0, 1'b0);
        tick("inst_ret2");
        clr_ex();
        for (int k = 0; k < 9; k++) begin
            pc_in = 32'h2040 + 32'(4 * k);
            tick("nest_call");
        end
        pc_in = 32'h30A0;
        for (int r = 1; r <= 9; r++) begin
            if (r == 9) begin
                #1;
                chk("ninth_ret.pred", branch_predict_pc_out, 32'h2064);
            end
            tick("nest_ret");
        end

        // Stalled call hit leaves GHR and RAS alone
        g0 = m_ghr; p0 = m_ptr;
        pc_in = 32'h2040; ctrl_stall = 1'b1;
        tick("stall_call");
        chk("stall.ghr", 32'(pred_ghr_out), g0);
        chk("stall.ptr", 32'(pred_ras_ptr_out), p0);
        ctrl_stall = 1'b0;

        // Randomised traffic against the model
        pool[0] = 32'h200;  pool[1] = 32'h300;  pool[2] = 32'h400;  pool[3] = 32'h820;
        pool[4] = 32'h2040; pool[5] = 32'h2048; pool[6] = 32'h30A0; pool[7] = 32'hFFFF_FFFC;
        pool[8] = 32'h1234; pool[9] = 32'h0;    pool[10] = 32'h2060; pool[11] = 32'h9A0;
        for (int i = 0; i < 400; i++) begin
            pc_in = pick();
            ctrl_stall = ($urandom_range(3) == 0);
            if ($urandom_range(1) == 1) begin
                branch_ex_req     = 1'b1;
                branch_ex_pc      = pick();
                branch_ex_type    = 2'($urandom_range(3));
                branch_ex_taken   = (branch_ex_type != BR_COND) ? 1'b1 : 1'($urandom_range(1));
                branch_ex_next_pc = $urandom & 32'hFFFF_FFFC;
                branch_ex_ghr     = 8'($urandom_range(255));
                branch_ex_ras_ptr = 3'($urandom_range(7));
                branch_miss       = ($urandom_range(3) == 0);
            end else begin
                clr_ex();
            end
            tick("rand");
        end
        clr_ex();
        ctrl_stall = 1'b0;

        // Asynchronous reset in the middle of a cycle
        pc_in = 32'h400;
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        chk("async_rst.taken", 32'(branch_taken_out), 32'd0);
        chk("async_rst.pred",  branch_predict_pc_out, 32'h404);
        chk("async_rst.ghr",   32'(pred_ghr_out), 32'd0);
        chk("async_rst.ptr",   32'(pred_ras_ptr_out), 32'd0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        tick("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
